// File: rtl/mult_mod_sq_seq.sv
// Repeated-squaring sequencer: issues T squarings of x to an external modular
// multiplier, then fully reduces the redundant result below MODULUS.
module mult_mod_sq_seq #(
  parameter int              BITS       = 392,
  parameter logic [BITS-1:0] MODULUS    = BITS'(381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab),
  parameter int              ITER_W     = 32,
  parameter int              REDUCE_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_val,
  output logic              o_rdy,
  input  logic [BITS-1:0]   i_dat,
  input  logic [ITER_W-1:0] i_iter,
  output logic              o_mul_val,
  input  logic              i_mul_rdy,
  output logic [BITS-1:0]   o_mul_dat_a,
  output logic [BITS-1:0]   o_mul_dat_b,
  input  logic              i_mul_val,
  output logic              o_mul_rdy,
  input  logic [BITS-1:0]   i_mul_dat,
  output logic              o_val,
  input  logic              i_rdy,
  output logic [BITS-1:0]   o_dat,
  output logic              o_err,
  output logic [2:0]        o_dbg_state
);

  // Handshakes: a transfer happens on a cycle where val && rdy are both high;
  // a raised val is held with stable data until that transfer occurs.

  localparam int SUB_W = $clog2(REDUCE_MAX + 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_REDUCE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [BITS-1:0]    x;
  logic [ITER_W-1:0]  cnt;
  logic [SUB_W-1:0]   sub_cnt;
  logic               err;
  logic               x_ge_mod;

  assign x_ge_mod = (x >= MODULUS);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (i_val) state_nx = (i_iter == '0) ? S_REDUCE : S_ISSUE;
      S_ISSUE:  if (i_mul_rdy) state_nx = S_WAIT;
      S_WAIT:   if (i_mul_val) state_nx = (cnt == ITER_W'(1)) ? S_REDUCE : S_ISSUE;
      S_REDUCE: if (!x_ge_mod) state_nx = S_DONE;
      S_DONE:   if (i_rdy) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Working operand doubles as the request operand and the final result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x       <= '0;
      cnt     <= '0;
      sub_cnt <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_val) begin
            x       <= i_dat;
            cnt     <= i_iter;
            sub_cnt <= '0;
            err     <= 1'b0;
          end
        end
        S_WAIT: begin
          if (i_mul_val) begin
            x   <= i_mul_dat;
            cnt <= cnt - ITER_W'(1);
          end
        end
        S_REDUCE: begin
          if (x_ge_mod) begin
            x <= x - MODULUS;
            // sub_cnt saturates one past the limit; err latches on overflow
            if (sub_cnt >= SUB_W'(REDUCE_MAX)) err <= 1'b1;
            if (sub_cnt != SUB_W'(REDUCE_MAX + 1)) sub_cnt <= sub_cnt + SUB_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are pure decodes of flopped state/data, so they change only on clk.
  assign o_rdy       = (state == S_IDLE);
  assign o_mul_val   = (state == S_ISSUE);
  assign o_mul_rdy   = (state == S_WAIT);
  assign o_val       = (state == S_DONE);
  assign o_mul_dat_a = x;
  assign o_mul_dat_b = x;
  assign o_dat       = x;
  assign o_err       = err;
  assign o_dbg_state = state;

endmodule
